// File: rtl/kid_motion_ctrl.sv
// Kid sprite motion controller: once per frame tick, turns buttons and collision
// flags into facing direction, animation action and sprite top-left position.
module kid_motion_ctrl #(
  parameter logic [9:0]  SPAWN_X  = 10'd32,
  parameter logic [9:0]  SPAWN_Y  = 10'd400,
  parameter int unsigned WALK_V   = 3,
  parameter int unsigned JUMP_V   = 8,
  parameter int unsigned DJUMP_V  = 7,
  parameter int unsigned GRAV_DIV = 2,
  parameter int unsigned MAX_FALL = 9,
  parameter logic [9:0]  MAX_X    = 10'd609,
  parameter logic [9:0]  DEATH_Y  = 10'd458
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [3:0] keys,
  input  logic [3:0] is_collide,
  output logic       direction,
  output logic [1:0] action,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y
);

  localparam int unsigned PW = 10;
  localparam int unsigned XW = PW + 1;
  localparam int unsigned SW = PW + 2;
  localparam int unsigned VW = 6;
  localparam int unsigned GW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

  localparam logic signed [VW-1:0] VY_JUMP  = -$signed(VW'(JUMP_V));
  localparam logic signed [VW-1:0] VY_DJUMP = -$signed(VW'(DJUMP_V));
  localparam logic signed [VW-1:0] VY_MAX   = $signed(VW'(MAX_FALL));
  localparam logic [GW-1:0]        GC_LAST  = GW'(GRAV_DIV - 1);

  localparam logic [1:0] ACT_IDLE = 2'b00;
  localparam logic [1:0] ACT_RUN  = 2'b01;
  localparam logic [1:0] ACT_JUMP = 2'b10;
  localparam logic [1:0] ACT_FALL = 2'b11;

  logic [PW-1:0]        pos_x_q, pos_x_d;
  logic [PW-1:0]        pos_y_q, pos_y_d;
  logic signed [VW-1:0] vy_q, vy_d;
  logic                 dir_q, dir_d;
  logic [1:0]           act_q, act_d;
  logic                 air_q, air_d;
  logic                 jprev_q, jprev_d;
  logic [GW-1:0]        gc_q, gc_d;

  logic                 grounded, jp, gc_wrap;
  logic                 blk_up, blk_dn, mv_l, mv_r, moved, respawn;
  logic signed [VW-1:0] vy_n;
  logic signed [SW-1:0] y_sum;
  logic [XW-1:0]        x_sum;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_x_q <= SPAWN_X;
      pos_y_q <= SPAWN_Y;
      vy_q    <= '0;
      dir_q   <= 1'b1;
      act_q   <= ACT_IDLE;
      air_q   <= 1'b1;
      jprev_q <= 1'b0;
      gc_q    <= '0;
    end else begin
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      vy_q    <= vy_d;
      dir_q   <= dir_d;
      act_q   <= act_d;
      air_q   <= air_d;
      jprev_q <= jprev_d;
      gc_q    <= gc_d;
    end
  end

  // Per-tick physics update; state holds between ticks
  always_comb begin
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    vy_d     = vy_q;
    dir_d    = dir_q;
    act_d    = act_q;
    air_d    = air_q;
    jprev_d  = jprev_q;
    gc_d     = gc_q;
    grounded = is_collide[1];
    jp       = keys[2] & ~jprev_q;
    gc_wrap  = (gc_q == GC_LAST);
    vy_n     = vy_q;
    y_sum    = '0;
    x_sum    = '0;
    blk_up   = 1'b0;
    blk_dn   = 1'b0;
    mv_l     = keys[0] & ~keys[1];
    mv_r     = keys[1] & ~keys[0];
    moved    = 1'b0;
    respawn  = 1'b0;

    if (tick) begin
      jprev_d = keys[2];
      gc_d    = gc_wrap ? '0 : gc_q + GW'(1);

      if (grounded && jp) begin
        vy_n  = VY_JUMP;
        air_d = 1'b1;
        gc_d  = '0;
      end else if (!grounded && jp && air_q) begin
        vy_n  = VY_DJUMP;
        air_d = 1'b0;
        gc_d  = '0;
      end else if (!keys[2] && vy_q[VW-1]) begin
        vy_n = vy_q >>> 1;
      end else if (grounded && !vy_q[VW-1]) begin
        vy_n  = '0;
        air_d = 1'b1;
      end else begin
        if (gc_wrap) vy_n = vy_q + VW'(1);
        if (vy_n > VY_MAX) vy_n = VY_MAX;
      end

      // Vertical move; upward saturates at row 0
      y_sum  = $signed({2'b00, pos_y_q}) + $signed({{(SW-VW){vy_n[VW-1]}}, vy_n});
      blk_up = vy_n[VW-1] & is_collide[0];
      blk_dn = ~vy_n[VW-1] & (|vy_n) & is_collide[1];
      if (blk_up) begin
        vy_n = '0;
      end else if (!blk_dn) begin
        if (y_sum[SW-1])            pos_y_d = '0;
        else if (|y_sum[SW-2:PW])   pos_y_d = '1;
        else                        pos_y_d = y_sum[PW-1:0];
      end
      vy_d = vy_n;

      if (mv_l) begin
        dir_d = 1'b0;
        if (!is_collide[2])
          pos_x_d = (pos_x_q < PW'(WALK_V)) ? '0 : pos_x_q - PW'(WALK_V);
      end else if (mv_r) begin
        dir_d = 1'b1;
        if (!is_collide[3]) begin
          x_sum   = {1'b0, pos_x_q} + XW'(WALK_V);
          pos_x_d = (x_sum > {1'b0, MAX_X}) ? MAX_X : x_sum[PW-1:0];
        end
      end
      moved = (pos_x_d != pos_x_q);

      if (vy_n[VW-1])   act_d = ACT_JUMP;
      else if (!grounded) act_d = ACT_FALL;
      else if (moved)   act_d = ACT_RUN;
      else              act_d = ACT_IDLE;

      // Respawn keeps the freshly sampled jump button so a held jump cannot relaunch
      respawn = keys[3] | (pos_y_d > DEATH_Y);
      if (respawn) begin
        pos_x_d = SPAWN_X;
        pos_y_d = SPAWN_Y;
        vy_d    = '0;
        dir_d   = 1'b1;
        act_d   = ACT_IDLE;
        air_d   = 1'b1;
        gc_d    = '0;
      end
    end
  end

  assign direction = dir_q;
  assign action    = act_q;
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;

endmodule
